// File: rtl/washer_pkg.sv
// Shared types and constants for the washer plant model.
// motor_state_t : drum motor states (encoding is visible on the motor_state port)
// FLT_*         : bit positions inside fault_code
// FAULT_W       : width of fault_code
package washer_pkg;

    typedef enum logic [1:0] {
        STOP     = 2'd0,
        FWD      = 2'd1,
        REV      = 2'd2,
        SPINDOWN = 2'd3
    } motor_state_t;

    localparam int FAULT_W      = 4;
    localparam int FLT_OVERFILL = 0;
    localparam int FLT_VALVE    = 1;
    localparam int FLT_DIR      = 2;
    localparam int FLT_DRY      = 3;

endpackage

// File: rtl/washer_tank_level.sv
// Saturating tank level integrator with valve protocol checks.
// clk, rst     : clock, asynchronous active-high reset
// fill, drain  : inlet / drain valve commands
// level        : registered tank level
// overfill_evt : fill requested while the tank is already full (this edge)
// valve_evt    : both valves requested together (this edge)
module washer_tank_level #(
    parameter int LEVEL_MAX  = 64,
    parameter int FILL_STEP  = 2,
    parameter int DRAIN_STEP = 4,
    localparam int LW        = $clog2(LEVEL_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill,
    input  logic          drain,
    output logic [LW-1:0] level,
    output logic          overfill_evt,
    output logic          valve_evt
);

    // One spare bit so the sum is compared against LEVEL_MAX before it can wrap.
    localparam logic [LW:0] MAX_X   = (LW + 1)'(LEVEL_MAX);
    localparam logic [LW:0] FILL_X  = (LW + 1)'(FILL_STEP);
    localparam logic [LW:0] DRAIN_X = (LW + 1)'(DRAIN_STEP);

    logic [LW:0]   level_x;
    logic [LW:0]   sum_x;
    logic [LW:0]   diff_x;
    logic [LW-1:0] next_level;

    always_comb begin
        level_x    = {1'b0, level};
        sum_x      = level_x + FILL_X;
        diff_x     = level_x - DRAIN_X;
        next_level = level;
        if (fill && !drain) begin
            next_level = (sum_x > MAX_X) ? LW'(MAX_X) : LW'(sum_x);
        end else if (drain && !fill) begin
            next_level = (level_x < DRAIN_X) ? '0 : LW'(diff_x);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= next_level;
        end
    end

    assign overfill_evt = fill && (level == LW'(LEVEL_MAX));
    assign valve_evt    = fill && drain;

endmodule

// File: rtl/washer_plant_model.sv
// Behavioural washer plant: tank level, drum motor and sticky protocol faults.
// clk, rst                  : clock (1 ms), asynchronous active-high reset
// ctrl_fill, ctrl_release   : inlet / drain valve commands
// ctrl_forward, ctrl_reverse: drum drive commands
// clr_fault                 : single-cycle pulse clearing fault_code
// level                     : registered tank level
// sens_full, sens_empty     : level == LEVEL_MAX / level == 0
// drum_moving               : motor not stopped
// motor_state               : STOP=0, FWD=1, REV=2, SPINDOWN=3
// fault_code, fault         : sticky fault bits and their OR
module washer_plant_model
    import washer_pkg::*;
#(
    parameter int LEVEL_MAX    = 64,
    parameter int FILL_STEP    = 2,
    parameter int DRAIN_STEP   = 4,
    parameter int SPINDOWN_CYC = 8,
    localparam int LW          = $clog2(LEVEL_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_fill,
    input  logic               ctrl_release,
    input  logic               ctrl_forward,
    input  logic               ctrl_reverse,
    input  logic               clr_fault,
    output logic [LW-1:0]      level,
    output logic               sens_full,
    output logic               sens_empty,
    output logic               drum_moving,
    output logic [1:0]         motor_state,
    output logic [FAULT_W-1:0] fault_code,
    output logic               fault
);

    localparam int            CW   = (SPINDOWN_CYC > 1) ? $clog2(SPINDOWN_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SPINDOWN_CYC - 1);

    motor_state_t       state, next_state;
    logic [CW-1:0]      cnt, next_cnt;
    logic               overfill_evt, valve_evt, dir_evt, dry_evt;
    logic [FAULT_W-1:0] new_faults;

    washer_tank_level #(
        .LEVEL_MAX (LEVEL_MAX),
        .FILL_STEP (FILL_STEP),
        .DRAIN_STEP(DRAIN_STEP)
    ) u_tank (
        .clk         (clk),
        .rst         (rst),
        .fill        (ctrl_fill),
        .drain       (ctrl_release),
        .level       (level),
        .overfill_evt(overfill_evt),
        .valve_evt   (valve_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STOP;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        dir_evt    = 1'b0;
        case (state)
            STOP: begin
                if (ctrl_forward && !ctrl_reverse) begin
                    next_state = FWD;
                end else if (ctrl_reverse && !ctrl_forward) begin
                    next_state = REV;
                end else if (ctrl_forward && ctrl_reverse) begin
                    dir_evt = 1'b1;
                end
            end
            FWD: begin
                if (ctrl_reverse || !ctrl_forward) begin
                    dir_evt    = ctrl_reverse;
                    next_state = SPINDOWN;
                    next_cnt   = LOAD;
                end
            end
            REV: begin
                if (ctrl_forward || !ctrl_reverse) begin
                    dir_evt    = ctrl_forward;
                    next_state = SPINDOWN;
                    next_cnt   = LOAD;
                end
            end
            SPINDOWN: begin
                // Drive requests during coast are flagged but never restart the count.
                dir_evt = ctrl_forward || ctrl_reverse;
                if (cnt == '0) begin
                    next_state = STOP;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: next_state = STOP;
        endcase
    end

    assign dry_evt = ((state == FWD) || (state == REV)) && (level == '0);

    always_comb begin
        new_faults               = '0;
        new_faults[FLT_OVERFILL] = overfill_evt;
        new_faults[FLT_VALVE]    = valve_evt;
        new_faults[FLT_DIR]      = dir_evt;
        new_faults[FLT_DRY]      = dry_evt;
    end

    // A clear on the same edge as a new fault keeps only the new fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_code <= '0;
        end else if (clr_fault) begin
            fault_code <= new_faults;
        end else begin
            fault_code <= fault_code | new_faults;
        end
    end

    assign sens_full   = (level == LW'(LEVEL_MAX));
    assign sens_empty  = (level == '0);
    assign drum_moving = (state != STOP);
    assign motor_state = state;
    assign fault       = |fault_code;

endmodule

// File: tb/tb_washer_plant_model.sv
// Self-checking bench for washer_plant_model: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_washer_plant_model;

    localparam int LMAX  = 64;
    localparam int FSTEP = 2;
    localparam int DSTEP = 4;
    localparam int COAST = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_fill = 1'b0, ctrl_release = 1'b0;
    logic       ctrl_forward = 1'b0, ctrl_reverse = 1'b0;
    logic       clr_fault = 1'b0;
    logic [6:0] level;
    logic       sens_full, sens_empty, drum_moving, fault;
    logic [1:0] motor_state;
    logic [3:0] fault_code;

    washer_plant_model dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_fill   (ctrl_fill),
        .ctrl_release(ctrl_release),
        .ctrl_forward(ctrl_forward),
        .ctrl_reverse(ctrl_reverse),
        .clr_fault   (clr_fault),
        .level       (level),
        .sens_full   (sens_full),
        .sens_empty  (sens_empty),
        .drum_moving (drum_moving),
        .motor_state (motor_state),
        .fault_code  (fault_code),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: drum mode 0 idle, 1 forward, 2 reverse, 3 coasting with
    // m_coast cycles of coasting still to go.
    int       m_level;
    int       m_mode;
    int       m_coast;
    logic [3:0] m_fault;
    bit       model_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_level = 0;
        m_mode  = 0;
        m_coast = 0;
        m_fault = 4'b0000;
    endfunction

    function automatic void model_update(input bit fi, input bit rl, input bit f, input bit r, input bit cl);
        int   old_level;
        logic [3:0] nf;
        old_level = m_level;
        nf        = 4'b0000;
        if (fi && !rl) m_level = (m_level + FSTEP > LMAX) ? LMAX : m_level + FSTEP;
        if (rl && !fi) m_level = (m_level < DSTEP) ? 0 : m_level - DSTEP;
        if (fi && old_level == LMAX) nf[0] = 1'b1;
        if (fi && rl) nf[1] = 1'b1;
        if ((m_mode == 1 || m_mode == 2) && old_level == 0) nf[3] = 1'b1;
        case (m_mode)
            0: begin
                if (f && r) nf[2] = 1'b1;
                else if (f) m_mode = 1;
                else if (r) m_mode = 2;
            end
            1, 2: begin
                if ((m_mode == 1 && r) || (m_mode == 2 && f)) nf[2] = 1'b1;
                if ((m_mode == 1 && (r || !f)) || (m_mode == 2 && (f || !r))) begin
                    m_mode  = 3;
                    m_coast = COAST;
                end
            end
            default: begin
                if (f || r) nf[2] = 1'b1;
                m_coast--;
                if (m_coast == 0) m_mode = 0;
            end
        endcase
        m_fault = cl ? nf : (m_fault | nf);
    endfunction

    always @(posedge clk) begin
        if (!rst) model_update(ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, clr_fault);
    end

    always @(negedge clk) begin
        if (!rst && model_live) begin
            check("level", level, m_level);
            check("sens_full", sens_full, m_level == LMAX);
            check("sens_empty", sens_empty, m_level == 0);
            check("drum_moving", drum_moving, m_mode != 0);
            check("motor_state", motor_state, m_mode);
            check("fault_code", fault_code, m_fault);
            check("fault", fault, m_fault != 4'b0000);
        end
    end

    task automatic step(input bit f, input bit r, input bit fi, input bit rl, input bit cl);
        ctrl_forward = f;
        ctrl_reverse = r;
        ctrl_fill    = fi;
        ctrl_release = rl;
        clr_fault    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input bit f, input bit r, input bit fi, input bit rl);
        for (int i = 0; i < n; i++) step(f, r, fi, rl, 1'b0);
    endtask

    // Reset pulse strictly between clock edges; outputs must clear with no edge.
    task automatic areset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, "_level"}, level, 0);
        check({tag, "_state"}, motor_state, 0);
        check({tag, "_fault"}, fault_code, 0);
        check({tag, "_empty"}, sens_empty, 1);
        check({tag, "_full"}, sens_full, 0);
        check({tag, "_moving"}, drum_moving, 0);
        m_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        m_reset();
        #3;
        check("rst_level", level, 0);
        check("rst_empty", sens_empty, 1);
        check("rst_full", sens_full, 0);
        check("rst_moving", drum_moving, 0);
        check("rst_fault", fault, 0);
        #4 rst = 1'b0;
        model_live = 1'b1;

        // Fill to saturation, then one fill while already full.
        steps(1, 0, 0, 1, 0);
        check("fill_first", level, 2);
        steps(31, 0, 0, 1, 0);
        check("fill_full_lvl", level, 64);
        check("fill_full_sens", sens_full, 1);
        check("fill_no_ovf_yet", fault_code, 0);
        steps(2, 0, 0, 1, 0);
        check("overfill_code", fault_code, 4'b0001);
        check("overfill_lvl", level, 64);

        // Drain to empty and hold at zero.
        steps(16, 0, 0, 0, 1);
        check("drain_lvl", level, 0);
        check("drain_empty", sens_empty, 1);
        steps(1, 0, 0, 0, 1);
        check("drain_hold", level, 0);
        check("drain_no_new", fault_code, 4'b0001);
        step(0, 0, 0, 0, 1);
        check("clr1", fault_code, 0);

        // Forward, coast for exactly COAST cycles, then reverse.
        steps(16, 0, 0, 1, 0);
        check("lvl32", level, 32);
        steps(1, 1, 0, 0, 0);
        check("fwd_state", motor_state, 1);
        steps(9, 1, 0, 0, 0);
        for (int i = 1; i <= COAST; i++) begin
            steps(1, 0, 0, 0, 0);
            check("coast_state", motor_state, 3);
        end
        steps(1, 0, 0, 0, 0);
        check("coast_done", motor_state, 0);
        steps(1, 0, 1, 0, 0);
        check("rev_state", motor_state, 2);
        check("rev_fault", fault_code, 0);
        steps(9, 0, 0, 0, 0);
        check("rev_stop", motor_state, 0);

        // Direct reversal while driving forward.
        steps(3, 1, 0, 0, 0);
        steps(1, 0, 1, 0, 0);
        check("dir_state", motor_state, 3);
        check("dir_code", fault_code, 4'b0100);
        steps(7, 0, 0, 0, 0);
        check("dir_coast7", motor_state, 3);
        steps(1, 0, 0, 0, 0);
        check("dir_stop", motor_state, 0);
        steps(1, 0, 0, 1, 1);
        check("valve_lvl", level, 32);
        check("valve_code", fault_code, 4'b0110);

        // Dry running and clear racing a re-asserted fault.
        step(0, 0, 0, 0, 1);
        steps(8, 0, 0, 0, 1);
        check("dry_lvl0", level, 0);
        steps(1, 1, 0, 0, 0);
        check("dry_fwd_nofault", fault_code, 0);
        steps(1, 1, 0, 0, 0);
        check("dry_code", fault_code, 4'b1000);
        step(1, 0, 0, 0, 1);
        check("dry_clr_race", fault_code, 4'b1000);
        steps(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("dry_clr_ok", fault_code, 0);
        steps(9, 0, 0, 0, 0);

        // Asynchronous reset mid-fill with a pending DIR fault while driving.
        areset("pre");
        steps(1, 1, 1, 0, 0);
        steps(10, 1, 0, 1, 0);
        check("mid_lvl", level, 20);
        check("mid_state", motor_state, 1);
        check("mid_code", fault_code, 4'b0100);
        areset("async");

        // Randomized traffic with persistent drive commands and level bias phases.
        begin
            bit f = 0, r = 0, bias_fill = 1;
            for (int i = 0; i < 1500; i++) begin
                int p, rl_p, fi_p;
                if (i % 60 == 0) bias_fill = !bias_fill;
                if ($urandom_range(0, 99) < 15) begin
                    p = $urandom_range(0, 19);
                    f = (p < 8) || (p == 19);
                    r = (p >= 8 && p < 16) || (p == 19);
                end
                fi_p = bias_fill ? 60 : 15;
                rl_p = bias_fill ? 10 : 55;
                step(f, r, $urandom_range(0, 99) < fi_p, $urandom_range(0, 99) < rl_p,
                     $urandom_range(0, 99) < 6);
                if ($urandom_range(0, 999) < 4) areset("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Behavioural plant for the washing register machine: the actuator/sensor end of the ctrl_fill / ctrl_release / ctrl_forward / ctrl_reverse interface.
- Integrates tank water level from the valve commands and tracks drum motion from the motor commands.
- Returns full/empty level sensors and a drum-moving indication to the controller.
- Latches protocol-violation faults so controller benches can self-check. Clock period is 1 ms.

Parameters:
- LEVEL_MAX, 64: tank capacity in level units; level saturates here.
- FILL_STEP, 2: level increase per cycle while filling.
- DRAIN_STEP, 4: level decrease per cycle while releasing.
- SPINDOWN_CYC, 8: cycles the drum coasts after drive is removed before it is stopped.
- LW, $clog2(LEVEL_MAX+1): level width (derived, not overridable).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ctrl_fill  in  1  inlet valve open
- ctrl_release  in  1  drain valve open
- ctrl_forward  in  1  drive drum forward
- ctrl_reverse  in  1  drive drum reverse
- clr_fault  in  1  single-cycle pulse; clears fault_code
- level  out  LW  current tank level (registered)
- sens_full  out  1  level == LEVEL_MAX
- sens_empty  out  1  level == 0
- drum_moving  out  1  motor state != STOP
- motor_state  out  2  STOP=0, FWD=1, REV=2, SPINDOWN=3
- fault_code  out  4  sticky bits: [0] OVERFILL, [1] VALVE, [2] DIR, [3] DRY
- fault  out  1  OR of fault_code

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge): level=0, motor_state=STOP, spindown count=0, fault_code=0. Therefore sens_empty=1, sens_full=0, drum_moving=0, fault=0.
- All inputs are sampled on the rising clk edge. Registered state updates on that edge.
- sens_full, sens_empty and drum_moving are pure decodes of registers, with no added latency.
- Level, per edge:
  - fill only: level = min(level+FILL_STEP, LEVEL_MAX).
  - release only: level = max(level-DRAIN_STEP, 0).
  - both: level holds; set VALVE.
  - neither: hold.
  - fill sampled while level==LEVEL_MAX (before update): set OVERFILL; level stays LEVEL_MAX.
  - Reaching LEVEL_MAX by saturation does not by itself set OVERFILL.
  - Arithmetic is done in LW+1 bits before saturation, so there is no wrap-around.
- Motor FSM, with f=ctrl_forward and r=ctrl_reverse:
  - STOP:
    - f&!r goes to FWD.
    - r&!f goes to REV.
    - f&r: stay STOP, set DIR.
  - FWD:
    - f&!r: stay.
    - !f&!r: go to SPINDOWN and load count=SPINDOWN_CYC-1.
    - any r: set DIR, go to SPINDOWN and load count.
  - REV: mirror of FWD.
  - SPINDOWN:
    - Any f or r: set DIR; the count keeps running (it is not reloaded).
    - count==0: go to STOP. Otherwise decrement.
    - The drum is therefore in SPINDOWN for exactly SPINDOWN_CYC cycles.
  - A direct FWD<->REV change is illegal; it must pass through SPINDOWN and STOP.
- DRY is set on any edge where the state is FWD or REV and level==0.
- Faults:
  - Each bit is sticky until rst or clr_fault.
  - If clr_fault and a new fault condition occur on the same edge, the new bit is set and all other bits are cleared.
  - fault_code updates one edge after the offending inputs are sampled.
- Faults never alter level or motor behaviour beyond what is stated above.

Decomposition:
- washer_pkg:
  - motor_state_t enum (STOP, FWD, REV, SPINDOWN)
  - fault bit index constants FLT_OVERFILL=0, FLT_VALVE=1, FLT_DIR=2, FLT_DRY=3
  - FAULT_W=4
- One sub-module, washer_tank_level: the saturating level integrator plus the OVERFILL/VALVE detection.
- The motor FSM, DRY detection and fault register stay in the top module.

Test Plan:
- Fill from reset with fill=1 for 34 cycles: level goes 2,4,...; level=64 and sens_full=1 after edge 32; edge 33 samples fill while full, so fault_code=4'b0001; level stays 64.
- From 64, release=1 for 16 cycles: level=0 and sens_empty=1 after edge 16; a 17th cycle holds 0; no new fault.
- Level 32, forward=1 for 10 cycles: motor_state=FWD after the first edge. Drop forward: SPINDOWN for exactly 8 cycles, then STOP. Then reverse=1: REV. fault_code=0 throughout.
- Level 32, forward for 3 cycles then reverse asserted immediately: DIR set, state goes to SPINDOWN, STOP after 8 cycles. fill and release together for 1 cycle: VALVE set, level unchanged at 32.
- Level 0, forward=1: FWD and DRY set. Pulse clr_fault while forward is still high: fault_code=4'b1000, because DRY re-asserts on that edge. Then drop forward and pulse clr_fault again: fault_code=0.
- Mid-fill at level 20, with a pending DIR fault and state FWD, assert rst asynchronously between edges: level=0, STOP, fault_code=0 immediately, with no clock edge.
